branch_predictor_btb: RTL and testbench

//  Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage pipeline.
//  IF stage does a combinational lookup with pc_if, giving a predicted next PC so taken branches no longer flush IF/ID/EX.
//  The EX/MEM stage feeds back resolved outcomes. The block updates its tables, flags mispredicts and supplies the redirect PC.

---
 rtl/branch_predictor_btb_if.sv | 41 ++++
 rtl/branch_predictor_btb.sv | 124 ++++++++++++
 tb/tb_branch_predictor_btb.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/branch_predictor_btb_if.sv
// Interface bundling the fetch-side lookup, the execute-side resolution
// feedback and the status outputs of the branch target buffer.
//   master : pipeline side (drives pc_if and upd_*, observes predictions,
//            mispredict/redirect and performance counters)
//   slave  : predictor side (the BTB itself)
interface branch_predictor_btb_if #(
  parameter int XLEN   = 64,
  parameter int STAT_W = 32
);
  // IF-stage lookup
  logic [XLEN-1:0]   pc_if;
  logic              pred_hit;
  logic              pred_taken;
  logic [XLEN-1:0]   pred_next_pc;
  // EX/MEM-stage resolution
  logic              upd_valid;
  logic [XLEN-1:0]   upd_pc;
  logic              upd_taken;
  logic [XLEN-1:0]   upd_target;
  logic              upd_pred_taken;
  logic [XLEN-1:0]   upd_pred_target;
  logic              mispredict;
  logic [XLEN-1:0]   redirect_pc;
  // Performance counters
  logic [STAT_W-1:0] branch_count;
  logic [STAT_W-1:0] mispred_count;

  modport master (
    output pc_if, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    input  pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc,
           branch_count, mispred_count
  );

  modport slave (
    input  pc_if, upd_valid, upd_pc, upd_taken, upd_target,
           upd_pred_taken, upd_pred_target,
    output pred_hit, pred_taken, pred_next_pc, mispredict, redirect_pc,
           branch_count, mispred_count
  );
endinterface

// File: rtl/branch_predictor_btb.sv
// Direct-mapped branch target buffer with 2-bit saturating direction
// counters and saturating branch/mispredict performance counters.
// Ports:
//   clk   : clock, all state changes on the rising edge
//   reset : synchronous active-high reset (clears valid bits, counters
//           to weakly-not-taken, performance counters to zero)
//   bp    : slave side of branch_predictor_btb_if (lookup at pc_if,
//           resolved-branch feedback, mispredict/redirect, counters)
// Lookup is fully combinational; a same-cycle update to the looked-up
// entry is only visible on the following cycle.
module branch_predictor_btb #(
  parameter int XLEN    = 64,
  parameter int ENTRIES = 16,
  parameter int STAT_W  = 32
) (
  input  logic               clk,
  input  logic               reset,
  branch_predictor_btb_if.slave bp
);
  localparam int IDX_W = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX_W - 2;

  logic              valid_q  [ENTRIES];
  logic              valid_d  [ENTRIES];
  logic [TAG_W-1:0]  tag_q    [ENTRIES];
  logic [TAG_W-1:0]  tag_d    [ENTRIES];
  logic [XLEN-1:0]   target_q [ENTRIES];
  logic [XLEN-1:0]   target_d [ENTRIES];
  logic [1:0]        ctr_q    [ENTRIES];
  logic [1:0]        ctr_d    [ENTRIES];

  logic [STAT_W-1:0] branch_count_q, branch_count_d;
  logic [STAT_W-1:0] mispred_count_q, mispred_count_d;

  logic [IDX_W-1:0]  lk_idx, up_idx;
  logic [TAG_W-1:0]  lk_tag, up_tag;
  logic              up_hit;

  assign lk_idx = bp.pc_if[IDX_W+1:2];
  assign lk_tag = bp.pc_if[XLEN-1:IDX_W+2];
  assign up_idx = bp.upd_pc[IDX_W+1:2];
  assign up_tag = bp.upd_pc[XLEN-1:IDX_W+2];
  assign up_hit = valid_q[up_idx] && (tag_q[up_idx] == up_tag);

  // Lookup. The stored target only reaches the output through pred_taken,
  // which requires a valid entry, so never-written targets cannot leak.
  always_comb begin
    bp.pred_hit     = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    bp.pred_taken   = bp.pred_hit && ctr_q[lk_idx][1];
    bp.pred_next_pc = bp.pred_taken ? target_q[lk_idx] : bp.pc_if + XLEN'(4);
  end

  // Resolution: a wrong direction, or a taken branch whose carried target
  // differs from the real one, both require a redirect.
  always_comb begin
    bp.mispredict  = bp.upd_valid &&
                     ((bp.upd_taken != bp.upd_pred_taken) ||
                      (bp.upd_taken && (bp.upd_pred_target != bp.upd_target)));
    bp.redirect_pc = bp.upd_taken ? bp.upd_target : bp.upd_pc + XLEN'(4);
  end

  generate
    for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
      always_comb begin
        valid_d[gi]  = valid_q[gi];
        tag_d[gi]    = tag_q[gi];
        target_d[gi] = target_q[gi];
        ctr_d[gi]    = ctr_q[gi];
        if (bp.upd_valid && (up_idx == IDX_W'(gi))) begin
          if (up_hit) begin
            if (bp.upd_taken) begin
              ctr_d[gi]    = (ctr_q[gi] == 2'b11) ? 2'b11 : ctr_q[gi] + 2'd1;
              target_d[gi] = bp.upd_target;
            end else begin
              ctr_d[gi]    = (ctr_q[gi] == 2'b00) ? 2'b00 : ctr_q[gi] - 2'd1;
            end
          end else if (bp.upd_taken) begin
            // Allocate over whatever occupied this slot, starting weakly taken.
            valid_d[gi]  = 1'b1;
            tag_d[gi]    = up_tag;
            target_d[gi] = bp.upd_target;
            ctr_d[gi]    = 2'b10;
          end
        end
      end

      // Tags and targets need no reset: a cleared valid bit masks them.
      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q[gi] <= 1'b0;
          ctr_q[gi]   <= 2'b01;
        end else begin
          valid_q[gi] <= valid_d[gi];
          ctr_q[gi]   <= ctr_d[gi];
        end
        tag_q[gi]    <= tag_d[gi];
        target_q[gi] <= target_d[gi];
      end
    end
  endgenerate

  // Performance counters stick at all-ones instead of wrapping.
  always_comb begin
    branch_count_d  = branch_count_q;
    mispred_count_d = mispred_count_q;
    if (bp.upd_valid && (branch_count_q != '1))
      branch_count_d = branch_count_q + STAT_W'(1);
    if (bp.mispredict && (mispred_count_q != '1))
      mispred_count_d = mispred_count_q + STAT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      branch_count_q  <= '0;
      mispred_count_q <= '0;
    end else begin
      branch_count_q  <= branch_count_d;
      mispred_count_q <= mispred_count_d;
    end
  end

  assign bp.branch_count  = branch_count_q;
  assign bp.mispred_count = mispred_count_q;
endmodule

// File: tb/tb_branch_predictor_btb.sv
module tb_branch_predictor_btb;
  localparam int XLEN    = 64;
  localparam int ENTRIES = 16;
  localparam int STAT_W  = 4;
  localparam int SMAX    = (1 << STAT_W) - 1;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  branch_predictor_btb_if #(.XLEN(XLEN), .STAT_W(STAT_W)) bus ();

  branch_predictor_btb #(.XLEN(XLEN), .ENTRIES(ENTRIES), .STAT_W(STAT_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bp    (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: a table keyed by (pc/4) mod ENTRIES holding the full
  // upper address (pc/4/ENTRIES) as tag and a small integer counter 0..3.
  bit          m_valid [ENTRIES];
  logic [63:0] m_tag   [ENTRIES];
  logic [63:0] m_tgt   [ENTRIES];
  int          m_ctr   [ENTRIES];
  int          m_bc, m_mc;

  // Last observed DUT outputs, for directed constant checks.
  logic        o_hit, o_taken, o_mp;
  logic [63:0] o_next, o_redir;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int midx(input logic [63:0] pc);
    return int'((pc / 4) % ENTRIES);
  endfunction

  function automatic logic [63:0] mtag(input logic [63:0] pc);
    return pc / (4 * ENTRIES);
  endfunction

  task automatic mlook(input logic [63:0] pc, output bit hit, output bit tk,
                       output logic [63:0] nx);
    int i;
    i   = midx(pc);
    hit = m_valid[i] && (m_tag[i] == mtag(pc));
    tk  = hit && (m_ctr[i] >= 2);
    nx  = tk ? m_tgt[i] : pc + 64'd4;
  endtask

  task automatic mreset();
    for (int i = 0; i < ENTRIES; i++) begin
      m_valid[i] = 1'b0;
      m_ctr[i]   = 1;
    end
    m_bc = 0;
    m_mc = 0;
  endtask

  // One clock of stimulus: drive at the falling edge, check combinational
  // outputs against the model, then apply the rising-edge update to the model.
  task automatic step(input bit rst, input logic [63:0] pc, input bit uv,
                      input logic [63:0] upc, input bit ut, input logic [63:0] utgt,
                      input bit upt, input logic [63:0] uptgt);
    bit          e_hit, e_tk, e_mp, uhit;
    logic [63:0] e_nx, e_rd;
    int          ui;
    @(negedge clk);
    reset               = rst;
    bus.pc_if           = pc;
    bus.upd_valid       = uv;
    bus.upd_pc          = upc;
    bus.upd_taken       = ut;
    bus.upd_target      = utgt;
    bus.upd_pred_taken  = upt;
    bus.upd_pred_target = uptgt;
    #1;
    mlook(pc, e_hit, e_tk, e_nx);
    e_mp = uv && ((ut != upt) || (ut && (uptgt != utgt)));
    e_rd = ut ? utgt : upc + 64'd4;
    o_hit = bus.pred_hit; o_taken = bus.pred_taken; o_next = bus.pred_next_pc;
    o_mp = bus.mispredict; o_redir = bus.redirect_pc;
    chk("pred_hit", 64'(bus.pred_hit), 64'(e_hit));
    chk("pred_taken", 64'(bus.pred_taken), 64'(e_tk));
    chk("pred_next_pc", bus.pred_next_pc, e_nx);
    chk("mispredict", 64'(bus.mispredict), 64'(e_mp));
    if (e_mp) chk("redirect_pc", bus.redirect_pc, e_rd);
    chk("branch_count", 64'(bus.branch_count), 64'(m_bc));
    chk("mispred_count", 64'(bus.mispred_count), 64'(m_mc));
    $display("t=%0t rst=%0b pc=%h hit=%0b tk=%0b nx=%h | uv=%0b upc=%h ut=%0b mp=%0b bc=%0d mc=%0d",
             $time, rst, pc, bus.pred_hit, bus.pred_taken, bus.pred_next_pc,
             uv, upc, ut, bus.mispredict, bus.branch_count, bus.mispred_count);
    @(posedge clk);
    if (rst) begin
      mreset();
    end else begin
      if (uv && m_bc < SMAX) m_bc++;
      if (e_mp && m_mc < SMAX) m_mc++;
      if (uv) begin
        ui   = midx(upc);
        uhit = m_valid[ui] && (m_tag[ui] == mtag(upc));
        if (uhit) begin
          if (ut) begin
            m_ctr[ui] = (m_ctr[ui] + 1 > 3) ? 3 : m_ctr[ui] + 1;
            m_tgt[ui] = utgt;
          end else begin
            m_ctr[ui] = (m_ctr[ui] - 1 < 0) ? 0 : m_ctr[ui] - 1;
          end
        end else if (ut) begin
          m_valid[ui] = 1'b1;
          m_tag[ui]   = mtag(upc);
          m_tgt[ui]   = utgt;
          m_ctr[ui]   = 2;
        end
      end
    end
  endtask

  task automatic look(input logic [63:0] pc);
    step(1'b0, pc, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
  endtask

  // Update at upc carrying the prediction the front end would have made.
  task automatic upd_pred(input logic [63:0] pc, input logic [63:0] upc,
                          input bit ut, input logic [63:0] utgt);
    bit          h, tk;
    logic [63:0] nx;
    mlook(upc, h, tk, nx);
    step(1'b0, pc, 1'b1, upc, ut, utgt, tk, nx);
  endtask

  function automatic logic [63:0] rpc();
    logic [63:0] t;
    case ($urandom_range(0, 3))
      0:       t = 64'h0;
      1:       t = 64'h1;
      2:       t = 64'h2;
      default: t = 64'h03FF_FFFF_FFFF_FFFF;
    endcase
    return (t << 6) | (64'($urandom_range(0, ENTRIES - 1)) << 2) | 64'($urandom_range(0, 3));
  endfunction

  initial begin
    reset = 1'b1;
    bus.pc_if = '0; bus.upd_valid = 1'b0; bus.upd_pc = '0; bus.upd_taken = 1'b0;
    bus.upd_target = '0; bus.upd_pred_taken = 1'b0; bus.upd_pred_target = '0;
    repeat (2) @(posedge clk);
    mreset();

    // Reset state seen through a lookup at 0x40.
    step(1'b1, 64'h40, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0);
    chk("t1_hit", 64'(o_hit), 64'h0);
    chk("t1_next", o_next, 64'h44);

    // First taken branch allocates and mispredicts.
    step(1'b0, 64'h40, 1'b1, 64'h40, 1'b1, 64'h80, 1'b0, 64'h44);
    chk("t2_mp", 64'(o_mp), 64'h1);
    chk("t2_redir", o_redir, 64'h80);
    look(64'h40);
    chk("t2_next", o_next, 64'h80);
    chk("t2_taken", 64'(o_taken), 64'h1);

    // Counter saturates high, then walks down and saturates low.
    repeat (2) upd_pred(64'h40, 64'h40, 1'b1, 64'h80);
    upd_pred(64'h40, 64'h40, 1'b0, 64'h0);
    look(64'h40); chk("t3_ctr10", 64'(o_taken), 64'h1);
    upd_pred(64'h40, 64'h40, 1'b0, 64'h0);
    look(64'h40); chk("t3_ctr01", 64'(o_taken), 64'h0);
    repeat (2) upd_pred(64'h40, 64'h40, 1'b0, 64'h0);
    look(64'h40); chk("t3_ctr00_hit", 64'(o_hit), 64'h1);
    upd_pred(64'h40, 64'h40, 1'b1, 64'h80);
    look(64'h40); chk("t3_from00", 64'(o_taken), 64'h0);

    // Aliasing: 0x440 shares the index of 0x40 and evicts it.
    upd_pred(64'h0, 64'h440, 1'b1, 64'h900);
    look(64'h40);  chk("t4_old_miss", 64'(o_hit), 64'h0);
    look(64'h440); chk("t4_new_next", o_next, 64'h900);

    // No bypass: lookup of an entry being allocated this cycle misses.
    upd_pred(64'h100, 64'h100, 1'b1, 64'h200);
    chk("t5_same_cycle", 64'(o_hit), 64'h0);
    look(64'h100); chk("t5_next_cycle", 64'(o_hit), 64'h1);

    // pc+4 wrap at the top of the address space.
    look(64'hFFFF_FFFF_FFFF_FFFC);
    chk("wrap_next", o_next, 64'h0);

    // Counter saturation: 20 mispredicting not-taken branches.
    repeat (20) step(1'b0, 64'h0, 1'b1, 64'h208, 1'b0, 64'h0, 1'b1, 64'h300);
    look(64'h0);
    chk("t6_mc_sat", 64'(bus.mispred_count), 64'hF);

    // Reset concurrent with an allocating update discards the update.
    step(1'b1, 64'h300, 1'b1, 64'h300, 1'b1, 64'h700, 1'b0, 64'h0);
    look(64'h300);
    chk("t6_rst_hit", 64'(o_hit), 64'h0);
    chk("t6_rst_bc", 64'(bus.branch_count), 64'h0);

    // Randomised traffic over a small address pool so entries hit and alias.
    for (int n = 0; n < 400; n++) begin
      logic [63:0] upc, pc;
      bit          ut;
      pc  = rpc();
      upc = rpc();
      ut  = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 99) == 0)
        step(1'b1, pc, 1'b1, upc, ut, {$urandom, $urandom}, 1'b0, 64'h0);
      else if ($urandom_range(0, 3) != 0)
        upd_pred(pc, upc, ut, (ut && $urandom_range(0, 1)) ? {$urandom, $urandom} : upc + 64'h40);
      else
        step(1'b0, pc, 1'($urandom_range(0, 1)), upc, ut, {$urandom, $urandom},
             1'($urandom_range(0, 1)), {$urandom, $urandom});
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
